// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bundle, operation encodings and saturation constants.
package alu_pkg;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
    logic c;
  } flags_t;

  typedef enum logic { OP_ADD = 1'b0, OP_SUB = 1'b1 } op_e;
  typedef enum logic { SGN_UNSIGNED = 1'b0, SGN_SIGNED = 1'b1 } sign_e;

  // Most-positive / most-negative two's-complement values for a w-bit word (w <= 64).
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  // v/n/c from the operand and raw-result sign bits; z is filled in by the caller.
  function automatic flags_t calc_flags(input logic a_msb, input logic bx_msb,
                                        input logic r_msb, input logic carry,
                                        input logic sub, input logic sign);
    flags_t f;
    f   = '0;
    f.c = carry;
    if (sign_e'(sign) == SGN_SIGNED) begin
      f.v = (a_msb == bx_msb) && (r_msb != a_msb);
      f.n = r_msb ^ f.v;
    end else if (op_e'(sub) == OP_SUB) begin
      f.v = !carry;
      f.n = !carry;
    end else begin
      f.v = carry;
      f.n = 1'b0;
    end
    return f;
  endfunction

endpackage

// File: rtl/pipe_addsub_seg.sv
// One SEG-bit slice of the carry chain; sum and carry-out are registered.
module addsub_seg
  import alu_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (en) begin
      sum  <= total[SEG-1:0];
      cout <= total[SEG];
    end
  end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor, one carry segment per register stage, with Z/V/N/C flags.
// Optional saturation on overflow is built when ADDSUB_SAT_EN is defined.
module pipe_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sign,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             c
);

  // WIDTH must be a multiple of STAGES.
  localparam int SEG = WIDTH / STAGES;

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));
  logic [STAGES-1:0] sat_q;
`endif

  logic [STAGES-1:0]           valid;
  logic [STAGES-1:0]           adv;
  logic [WIDTH-1:0]            a_q   [STAGES];
  logic [WIDTH-1:0]            bx_q  [STAGES];
  logic [WIDTH-1:0]            res_q [STAGES];
  logic [WIDTH-1:0]            res_w [STAGES];
  logic [STAGES-1:0]           sub_q;
  logic [STAGES-1:0]           sign_q;
  logic [STAGES-1:0][SEG-1:0]  seg_a;
  logic [STAGES-1:0][SEG-1:0]  seg_b;
  logic [STAGES-1:0][SEG-1:0]  seg_sum;
  logic [STAGES-1:0]           seg_cin;
  logic [STAGES-1:0]           seg_cout;
  logic [WIDTH-1:0]            bx;
  flags_t                      flags;

  assign bx = sub ? ~b : b;

  // Handshake: a transfer happens on a rising edge where valid && ready; a stage
  // loads when it is empty or its occupant moves on, so in_ready = adv[0].
  always_comb begin
    logic go;
    go = !valid[STAGES-1] || out_ready;
    adv[STAGES-1] = go;
    for (int k = STAGES - 2; k >= 0; k--) begin
      go     = !valid[k] || go;
      adv[k] = go;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid[STAGES-1];

  always_comb begin
    seg_a[0]   = a[SEG-1:0];
    seg_b[0]   = bx[SEG-1:0];
    seg_cin[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      seg_a[k]   = a_q[k-1][k*SEG +: SEG];
      seg_b[k]   = bx_q[k-1][k*SEG +: SEG];
      seg_cin[k] = seg_cout[k-1];
    end
  end

  // Result so far at stage k: lower slices carried in res_q, slice k from the segment.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      res_w[k] = res_q[k];
      res_w[k][k*SEG +: SEG] = seg_sum[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    addsub_seg #(.SEG(SEG)) u_seg (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (adv[k]),
      .a    (seg_a[k]),
      .b    (seg_b[k]),
      .cin  (seg_cin[k]),
      .sum  (seg_sum[k]),
      .cout (seg_cout[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= '0;
      sub_q  <= '0;
      sign_q <= '0;
`ifdef ADDSUB_SAT_EN
      sat_q  <= '0;
`endif
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
        res_q[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        valid[0]  <= in_valid;
        a_q[0]    <= a;
        bx_q[0]   <= bx;
        res_q[0]  <= '0;
        sub_q[0]  <= sub;
        sign_q[0] <= sign;
`ifdef ADDSUB_SAT_EN
        sat_q[0]  <= sat;
`endif
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          valid[k]  <= valid[k-1];
          a_q[k]    <= a_q[k-1];
          bx_q[k]   <= bx_q[k-1];
          res_q[k]  <= res_w[k-1];
          sub_q[k]  <= sub_q[k-1];
          sign_q[k] <= sign_q[k-1];
`ifdef ADDSUB_SAT_EN
          sat_q[k]  <= sat_q[k-1];
`endif
        end
      end
    end
  end

  // Flags describe the unsaturated event; only z looks at the value actually output.
  always_comb begin
    r     = res_w[STAGES-1];
    flags = calc_flags(a_q[STAGES-1][WIDTH-1], bx_q[STAGES-1][WIDTH-1],
                       res_w[STAGES-1][WIDTH-1], seg_cout[STAGES-1],
                       sub_q[STAGES-1], sign_q[STAGES-1]);
`ifdef ADDSUB_SAT_EN
    if (sat_q[STAGES-1] && flags.v) begin
      if (sign_q[STAGES-1]) r = a_q[STAGES-1][WIDTH-1] ? SMIN : SMAX;
      else if (sub_q[STAGES-1]) r = '0;
      else r = '1;
    end
`endif
    flags.z = valid[STAGES-1] && (r == '0);
  end

  assign {z, v, n, c} = flags;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=32, STAGES=4); covers ADDSUB_SAT_EN when defined.
module tb_pipe_addsub;

  localparam int W  = 32;
  localparam int S  = 4;
  localparam int OW = W + 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         sign = 1'b0;
  logic         sat = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] r;
  logic         z, v, n, c;

  logic [OW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;

  logic          in_fire, out_fire, ov, ir;
  logic [OW-1:0] obs;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .sign     (sign),
`ifdef ADDSUB_SAT_EN
    .sat      (sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r        (r),
    .z        (z),
    .v        (v),
    .n        (n),
    .c        (c)
  );

  // Reference: exact integer arithmetic, then the flag definitions applied to the true result.
  function automatic logic [OW-1:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                          input logic isub, input logic isign, input logic isat);
    longint ua, ub, sa, sb, t, smax, smin, umax;
    logic [W-1:0] rr;
    logic zz, vv, nn, cc;
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    umax = (longint'(1) <<< W) - 1;
    ua = longint'(ia);
    ub = longint'(ib);
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    if (isign) begin
      t  = isub ? sa - sb : sa + sb;
      vv = (t > smax) || (t < smin);
      nn = (t < 0);
    end else begin
      t  = isub ? ua - ub : ua + ub;
      vv = isub ? (ua < ub) : (t > umax);
      nn = isub && (ua < ub);
    end
    cc = isub ? (ua >= ub) : ((ua + ub) > umax);
    rr = W'(t);
    if (isat && vv) begin
`ifdef ADDSUB_SAT_EN
      if (isign) rr = (t > smax) ? W'(smax) : W'(smin);
      else rr = isub ? '0 : '1;
`endif
    end
    zz = (rr == '0);
    return {rr, zz, vv, nn, cc};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h1;
      default: return W'($urandom);
    endcase
  endfunction

  // Drive one cycle's inputs, sample outputs before the edge, then move to the next low phase.
  task automatic drive_cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic isub, input logic isign, input logic isat,
                             input logic ordy);
    in_valid = iv; a = ia; b = ib; sub = isub; sign = isign; sat = isat; out_ready = ordy;
    #1;
    ov       = out_valid;
    ir       = in_ready;
    in_fire  = iv && in_ready;
    out_fire = out_valid && ordy;
    obs      = {r, z, v, n, c};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_single(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                            input logic isign, input logic isat,
                            output logic found, output logic [OW-1:0] res);
    found = 1'b0;
    res   = '0;
    drive_cycle(1'b1, ia, ib, isub, isign, isat, 1'b1);
    for (int i = 0; i < 20 && !found; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (ov) begin
        found = 1'b1;
        res   = obs;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if ({r, z, v, n, c} !== '0) $display("FAIL reset_outputs: got %h expected 0", {r, z, v, n, c});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b expected 0", out_valid);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_latency();
    drive_cycle(1'b1, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (in_fire !== 1'b1) $display("FAIL lat_accept: got %b expected 1", in_fire);
    else n_pass++;
    for (int i = 1; i <= S; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (ov !== (i == S)) $display("FAIL lat_valid_cycle%0d: got %b expected %b", i, ov, (i == S));
      else n_pass++;
      if (i == S) begin
        n_checks++;
        if (obs !== {32'd12, 4'b0000}) $display("FAIL lat_result: got %h expected %h", obs, {32'd12, 4'b0000});
        else n_pass++;
      end
    end
  endtask

  task automatic test_corners();
    typedef struct packed {
      logic [W-1:0]  ta;
      logic [W-1:0]  tb;
      logic          tsub;
      logic          tsign;
      logic          tsat;
      logic [OW-1:0] texp;
    } corner_t;
    corner_t       tbl[$];
    corner_t       e;
    logic          found;
    logic [OW-1:0] res;
    // expected = {r, z, v, n, c}
    tbl.push_back({32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, {32'h8000_0000, 4'b0100}});
    tbl.push_back({32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, {32'h0000_0000, 4'b1101}});
    tbl.push_back({32'h3,         32'h5, 1'b1, 1'b0, 1'b0, {32'hFFFF_FFFE, 4'b0110}});
    tbl.push_back({32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b0, {32'h7FFF_FFFF, 4'b0111}});
    tbl.push_back({32'h7,         32'h7, 1'b1, 1'b1, 1'b0, {32'h0000_0000, 4'b1001}});
    tbl.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, {32'hFFFF_FFFE, 4'b0011}});
`ifdef ADDSUB_SAT_EN
    tbl.push_back({32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, {32'h7FFF_FFFF, 4'b0100}});
    tbl.push_back({32'h3,         32'h5, 1'b1, 1'b0, 1'b1, {32'h0000_0000, 4'b1110}});
    tbl.push_back({32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, {32'hFFFF_FFFF, 4'b0101}});
    tbl.push_back({32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b1, {32'h8000_0000, 4'b0111}});
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i];
      run_single(e.ta, e.tb, e.tsub, e.tsign, e.tsat, found, res);
      n_checks++;
      if (!found) $display("FAIL corner%0d_timeout: got no output expected %h", i, e.texp);
      else n_pass++;
      n_checks++;
      if (res !== e.texp) $display("FAIL corner%0d: got %h expected %h", i, res, e.texp);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int            sent = 0;
    int            got = 0;
    logic          saw_drop = 1'b0;
    logic          held_v = 1'b0;
    logic          ordy;
    logic [OW-1:0] held = '0;
    logic [OW-1:0] expv;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      ordy = !(cyc >= 6 && cyc <= 9);
      drive_cycle(sent < 10, W'(sent), W'(sent), 1'b0, 1'b0, 1'b0, ordy);
      if (sent < 10 && !ir) saw_drop = 1'b1;
      if (ov && !ordy) begin
        if (held_v) begin
          n_checks++;
          if (obs !== held) $display("FAIL bp_hold_cycle%0d: got %h expected %h", cyc, obs, held);
          else n_pass++;
        end
        held   = obs;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (in_fire) sent++;
      if (out_fire) begin
        expv = {W'(2 * got), (got == 0), 3'b000};
        n_checks++;
        if (obs !== expv) $display("FAIL bp_result%0d: got %h expected %h", got, obs, expv);
        else n_pass++;
        got++;
      end
    end
    n_checks++;
    if (got != 10) $display("FAIL bp_count: got %0d expected 10", got);
    else n_pass++;
    n_checks++;
    if (!saw_drop) $display("FAIL bp_in_ready_drop: got %b expected 1", saw_drop);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int            sent = 0;
    int            got = 0;
    logic [W-1:0]  ta, tb;
    logic          tsub, tsign;
    logic [OW-1:0] expv;
    exp_q.delete();
    for (int cyc = 0; cyc < 24 + S; cyc++) begin
      ta = pick(); tb = pick();
      tsub = 1'($urandom_range(0, 1)); tsign = 1'($urandom_range(0, 1));
      drive_cycle(cyc < 24, ta, tb, tsub, tsign, 1'b0, 1'b1);
      if (in_fire) begin
        exp_q.push_back(model(ta, tb, tsub, tsign, 1'b0));
        sent++;
      end
      if (out_fire) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra: got %h expected none", obs);
        else begin
          expv = exp_q.pop_front();
          if (obs !== expv) $display("FAIL b2b_result: got %h expected %h", obs, expv);
          else n_pass++;
        end
        got++;
      end
    end
    n_checks++;
    if (sent != 24) $display("FAIL b2b_accepted: got %0d expected 24", sent);
    else n_pass++;
    n_checks++;
    if (got != 24) $display("FAIL b2b_emitted: got %0d expected 24", got);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0]  ta, tb;
    logic          tsub, tsign, tsat, tv, trdy;
    logic [OW-1:0] expv;
    int            drain = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 300 + 60; cyc++) begin
      if (cyc >= 300 && exp_q.size() == 0) break;
      ta = pick(); tb = pick();
      tsub  = 1'($urandom_range(0, 1));
      tsign = 1'($urandom_range(0, 1));
`ifdef ADDSUB_SAT_EN
      tsat  = 1'($urandom_range(0, 1));
`else
      tsat  = 1'b0;
`endif
      tv   = (cyc < 300) && ($urandom_range(0, 3) != 0);
      trdy = (cyc >= 300) || ($urandom_range(0, 2) != 0);
      drive_cycle(tv, ta, tb, tsub, tsign, tsat, trdy);
      if (cyc >= 300) drain++;
      if (in_fire) exp_q.push_back(model(ta, tb, tsub, tsign, tsat));
      if (out_fire) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rand_extra: got %h expected none", obs);
        else begin
          expv = exp_q.pop_front();
          if (obs !== expv) $display("FAIL rand_result: got %h expected %h", obs, expv);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rand_drain: got %0d pending expected 0 (drain cycles %0d)", exp_q.size(), drain);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic          seen = 1'b0;
    logic          found;
    logic [OW-1:0] res;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, W'(i + 1), 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !ov; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ov !== 1'b1) $display("FAIL arst_pre_valid: got %b expected 1", ov);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL arst_immediate: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if ({r, z, v, n, c} !== '0) $display("FAIL arst_outputs: got %h expected 0", {r, z, v, n, c});
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (ov) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL arst_ghost_output: got 1 expected 0");
    else n_pass++;
    run_single(32'd9, 32'd4, 1'b1, 1'b1, 1'b0, found, res);
    n_checks++;
    if (!found || res !== {32'd5, 4'b0001}) $display("FAIL arst_next_op: got %h expected %h", res, {32'd5, 4'b0001});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
